// File: rtl/dsk_sector_buffer.sv
// One-sector (512 B) cache between the FDC and mist_io SD block access.
// Read hits are served from the buffer; misses and write-backs run an sd_rd/sd_wr/sd_ack handshake.
module dsk_sector_buffer #(
  parameter int DRIVE = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  img_mounted,
  input  logic [63:0] img_size,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [8:0]  fdc_addr,
  input  logic [7:0]  fdc_din,
  input  logic        fdc_we,
  output logic [7:0]  fdc_dout,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr
);

  typedef enum logic [2:0] {
    IDLE, CHECK, RD_REQ, RD_XFER, WR_REQ, WR_XFER, FIN
  } state_t;

  state_t      state, nxt;
  logic [7:0]  ram [0:511];
  logic [31:0] lba_q, cached_lba;
  logic        wr_q, valid, rej, inval, ack_d;
  logic [54:0] sectors;
  logic        out_of_range, hit, mount, ack_fall, start;
  logic        unused_ok;

  assign sectors      = img_size[63:9];
  assign out_of_range = (sectors == '0) || ({23'd0, lba_q} >= sectors);
  assign hit          = !wr_q && valid && (lba_q == cached_lba);
  assign mount        = img_mounted[DRIVE];
  assign ack_fall     = ack_d && !sd_ack;
  assign start        = (state == IDLE) && (req_rd || req_wr);
  assign unused_ok    = ^{img_size[8:0], img_mounted};

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_rd || req_wr) nxt = CHECK;
      CHECK: begin
        if (out_of_range || hit) nxt = FIN;
        else if (wr_q)           nxt = WR_REQ;
        else                     nxt = RD_REQ;
      end
      RD_REQ:  if (sd_ack) nxt = RD_XFER;
      WR_REQ:  if (sd_ack) nxt = WR_XFER;
      RD_XFER: if (ack_fall) nxt = FIN;
      WR_XFER: if (ack_fall) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sd_rd      <= '0;
      sd_wr      <= '0;
      sd_lba     <= '0;
      valid      <= 1'b0;
      cached_lba <= '0;
      lba_q      <= '0;
      wr_q       <= 1'b0;
      rej        <= 1'b0;
      inval      <= 1'b0;
      ack_d      <= 1'b0;
    end else begin
      state <= nxt;
      ack_d <= sd_ack;
      busy  <= (nxt != IDLE);
      done  <= (state == FIN);
      sd_rd <= '0;
      sd_wr <= '0;
      if (nxt == RD_REQ) sd_rd[DRIVE] <= 1'b1;
      if (nxt == WR_REQ) sd_wr[DRIVE] <= 1'b1;
      if (start) begin
        lba_q <= req_lba;
        wr_q  <= req_wr;
        err   <= 1'b0;
        inval <= 1'b0;
      end
      if (state == CHECK) begin
        rej <= out_of_range;
        if (nxt == RD_REQ || nxt == WR_REQ) sd_lba <= lba_q;
      end
      if (state == FIN) err <= rej;
      if ((state == RD_XFER || state == WR_XFER) && ack_fall) begin
        cached_lba <= lba_q;
        valid      <= !inval;
      end
      // A mount seen at any point of a transfer keeps the result from being cached.
      if (mount) begin
        valid <= 1'b0;
        inval <= 1'b1;
      end
    end
  end

  // FDC write is placed last so it wins over an SD write to the same byte.
  always_ff @(posedge clk_sys) begin
    if (state == RD_XFER && sd_buff_wr) ram[sd_buff_addr] <= sd_buff_dout;
    if (fdc_we) ram[fdc_addr] <= fdc_din;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fdc_dout    <= '0;
      sd_buff_din <= '0;
    end else begin
      fdc_dout    <= ram[fdc_addr];
      sd_buff_din <= ram[sd_buff_addr];
    end
  end

endmodule

// File: tb/tb_dsk_sector_buffer.sv
// Directed bench for dsk_sector_buffer with an inline SD transfer model on drive 0.
module tb_dsk_sector_buffer;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  img_mounted = '0;
  logic [63:0] img_size = '0;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [31:0] req_lba = '0;
  logic        busy, done, err;
  logic [8:0]  fdc_addr = '0;
  logic [7:0]  fdc_din = '0;
  logic        fdc_we = 1'b0;
  logic [7:0]  fdc_dout;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr = 1'b0;

  dsk_sector_buffer #(.DRIVE(0)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .busy(busy), .done(done), .err(err),
    .fdc_addr(fdc_addr), .fdc_din(fdc_din), .fdc_we(fdc_we), .fdc_dout(fdc_dout),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0, bad = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic rd_p = 1'b0, wr_p = 1'b0;
  logic [7:0] cap [0:511];
  int rd0, wr0, dn0;

  // Handshake and completion counters, sampled mid-cycle.
  always @(posedge clk_sys) begin
    #2;
    if (sd_rd[0] && !rd_p) rd_cnt++;
    if (sd_wr[0] && !wr_p) wr_cnt++;
    if (done) done_cnt++;
    rd_p = sd_rd[0];
    wr_p = sd_wr[0];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge one cycle after the request was sampled.
  task automatic pulse(input logic rd, input logic wr, input logic [31:0] lba);
    @(negedge clk_sys);
    req_rd = rd; req_wr = wr; req_lba = lba;
    @(negedge clk_sys);
    req_rd = 1'b0; req_wr = 1'b0; req_lba = '0;
  endtask

  task automatic mount0();
    @(negedge clk_sys);
    img_mounted = 2'b01;
    @(negedge clk_sys);
    img_mounted = 2'b00;
  endtask

  task automatic expect_quick(input string tag, input logic exp_err);
    check({tag, "_busy1"}, busy, 1);
    @(negedge clk_sys);
    check({tag, "_nodone"}, done, 0);
    @(negedge clk_sys);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy0"}, busy, 0);
    @(negedge clk_sys);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  // Called at the negedge where sd_rd[0] must already be high.
  task automatic sd_read(input string tag, input logic [31:0] lba);
    check({tag, "_sd_rd"}, sd_rd[0], 1);
    check({tag, "_sd_lba"}, sd_lba, lba);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check({tag, "_rd_drop"}, sd_rd[0], 0);
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      sd_buff_dout = 8'(i);
      sd_buff_wr = 1'b1;
      @(negedge clk_sys);
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    @(negedge clk_sys);
    check({tag, "_early_done"}, done, 0);
    @(negedge clk_sys);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic sd_write(input string tag, input logic [31:0] lba);
    check({tag, "_sd_wr"}, sd_wr[0], 1);
    check({tag, "_no_sd_rd"}, sd_rd[0], 0);
    check({tag, "_sd_lba"}, sd_lba, lba);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check({tag, "_wr_drop"}, sd_wr[0], 0);
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      @(negedge clk_sys);
      cap[i] = sd_buff_din;
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    check({tag, "_early_done"}, done, 0);
    @(negedge clk_sys);
    check({tag, "_done"}, done, 1);
  endtask

  task automatic fdc_read(input string tag, input logic [8:0] addr, input logic [7:0] exp);
    @(negedge clk_sys);
    fdc_addr = addr;
    @(negedge clk_sys);
    check(tag, fdc_dout, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_sd_lba", sd_lba, 0);
    check("rst_fdc_dout", fdc_dout, 0);
    check("rst_sd_buff_din", sd_buff_din, 0);
    reset = 1'b0;

    // First read of LBA 5 from a 1 MiB image
    img_size = 64'd1048576;
    mount0();
    pulse(1, 0, 32'd5);
    check("rd5_busy", busy, 1);
    check("rd5_no_rd_yet", sd_rd[0], 0);
    @(negedge clk_sys);
    sd_read("rd5", 32'd5);
    fdc_read("rd5_ram1ff", 9'h1FF, 8'hFF);
    fdc_read("rd5_ram023", 9'h023, 8'h23);

    // Repeat read hits the buffer
    rd0 = rd_cnt;
    pulse(1, 0, 32'd5);
    expect_quick("hit5", 0);
    check("hit5_no_sd", rd_cnt, rd0 + 0);

    // Mount invalidates the cached sector
    mount0();
    rd0 = rd_cnt;
    pulse(1, 0, 32'd5);
    @(negedge clk_sys);
    sd_read("remount5", 32'd5);
    check("remount5_one_rd", rd_cnt, rd0 + 1);

    // FDC byte write then write-back to LBA 7
    @(negedge clk_sys);
    fdc_addr = 9'h010; fdc_din = 8'hA5; fdc_we = 1'b1;
    @(negedge clk_sys);
    fdc_we = 1'b0;
    pulse(0, 1, 32'd7);
    @(negedge clk_sys);
    sd_write("wr7", 32'd7);
    check("wr7_cap10", cap[16], 8'hA5);
    check("wr7_cap11", cap[17], 8'h11);
    check("wr7_cap1ff", cap[511], 8'hFF);

    // Out-of-range and boundary LBAs
    rd0 = rd_cnt;
    pulse(1, 0, 32'd2048);
    expect_quick("oor2048", 1);
    @(negedge clk_sys);
    check("oor_err_held", err, 1);
    pulse(1, 0, 32'd2047);
    check("lba2047_err_clr", err, 0);
    @(negedge clk_sys);
    sd_read("lba2047", 32'd2047);
    img_size = 64'd0;
    rd0 = rd_cnt;
    pulse(1, 0, 32'd0);
    expect_quick("noimg", 1);
    check("reject_no_sd", rd_cnt, rd0 + 0);

    // Simultaneous rd+wr is a write; a request while busy is ignored
    img_size = 64'd1048576;
    mount0();
    @(negedge clk_sys);
    dn0 = done_cnt;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    pulse(1, 1, 32'd3);
    req_rd = 1'b1; req_lba = 32'd9;
    @(negedge clk_sys);
    req_rd = 1'b0; req_lba = '0;
    sd_write("both3", 32'd3);
    repeat (6) @(negedge clk_sys);
    check("both3_one_done", done_cnt, dn0 + 1);
    check("both3_one_wr", wr_cnt, wr0 + 1);
    check("both3_no_rd", rd_cnt, rd0 + 0);

    // Written sector is now cached
    pulse(1, 0, 32'd3);
    expect_quick("hit3", 0);

    // Reset during an SD read request
    pulse(1, 0, 32'd9);
    @(negedge clk_sys);
    check("rst9_sd_rd_hi", sd_rd[0], 1);
    reset = 1'b1;
    #1;
    check("rst9_sd_rd_lo", sd_rd[0], 0);
    check("rst9_busy_lo", busy, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    pulse(1, 0, 32'd3);
    @(negedge clk_sys);
    sd_read("after_rst3", 32'd3);
    fdc_read("after_rst_ram010", 9'h010, 8'h10);

    repeat (4) @(negedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsk_sector_buffer.md
# dsk_sector_buffer

Single-sector (512-byte) buffer and request sequencer between the floppy controller inside `tatung` and the SD block interface of `mist_io`. It turns FDC sector read/write requests into `sd_rd`/`sd_wr`/`sd_ack` transactions, holds the sector in dual-port RAM for byte access by the FDC, and serves repeated reads of the same LBA from the buffer. Image mount events invalidate the cached sector. Accesses beyond the mounted image size are rejected.

## Interface
- `DRIVE`, 0: index of the `sd_rd`/`sd_wr`/`img_mounted` bit this instance owns (0 or 1).
- `clk_sys`  in  1  system clock (32 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `img_mounted`  in  2  one-cycle mount pulse per drive.
- `img_size`  in  64  mounted image size in bytes.
- `req_rd`  in  1  one-cycle pulse: load sector `req_lba`.
- `req_wr`  in  1  one-cycle pulse: write buffer back to `req_lba`.
- `req_lba`  in  32  sector number, sampled on `req_rd`/`req_wr`.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle pulse at request completion.
- `err`  out  1  set with `done` when a request was rejected; held until next request.
- `fdc_addr`  in  9  FDC byte address into buffer.
- `fdc_din`  in  8  FDC write data.
- `fdc_we`  in  1  FDC byte write strobe.
- `fdc_dout`  out  8  buffer byte at `fdc_addr`, registered.
- `sd_lba`  out  32  LBA presented to `mist_io`.
- `sd_rd`  out  2  read request, only bit `DRIVE` used.
- `sd_wr`  out  2  write request, only bit `DRIVE` used.
- `sd_ack`  in  1  `mist_io` transfer acknowledge.
- `sd_buff_addr`  in  9  `mist_io` byte address.
- `sd_buff_dout`  in  8  byte from SD (read).
- `sd_buff_din`  out  8  byte to SD (write), registered.
- `sd_buff_wr`  in  1  write strobe for `sd_buff_dout`.

## Operation
- States: IDLE, CHECK, RD_REQ, RD_XFER, WR_REQ, WR_XFER, FIN.
- IDLE: on `req_rd`/`req_wr` latch LBA and direction, go CHECK. `req_rd` and `req_wr` in the same cycle: `req_wr` wins. Requests while `busy` are ignored.
- CHECK: if `img_size[63:9] == 0` or `{32'd0, lba} >= img_size[63:9]`, set `err`, go FIN. Read with `valid && lba == cached_lba`: go FIN, no SD traffic (hit). Otherwise go RD_REQ or WR_REQ.
- RD_REQ/WR_REQ: drive `sd_lba`. Hold `sd_rd[DRIVE]` (resp. `sd_wr[DRIVE]`) high until `sd_ack` is seen high, then drop it and enter the XFER state.
- RD_XFER: each `sd_buff_wr` writes `sd_buff_dout` to RAM[`sd_buff_addr`]. On `sd_ack` falling: `cached_lba <= lba`, `valid <= 1`, go FIN.
- WR_XFER: `sd_buff_din` = RAM[`sd_buff_addr`]. On `sd_ack` falling: `cached_lba <= lba`, `valid <= 1`, go FIN.
- FIN: pulse `done` for one cycle, return to IDLE.
- FDC port is independent of the state machine. `fdc_we` writes RAM[`fdc_addr`] at any time. The FDC must not write during RD_XFER; if it does, the later write wins.
- `img_mounted[DRIVE]` pulse: `valid <= 0` immediately. If the pulse arrives during RD_XFER, the transfer completes but `valid` stays 0.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `sd_rd`=0, `sd_wr`=0, `sd_lba`=0, `fdc_dout`=0, `sd_buff_din`=0, `valid`=0, state IDLE. RAM contents are not reset.
- `busy` rises the cycle after the request pulse and falls in the cycle `done` is high.
- Read hit or rejected request: `done` 3 cycles after the request pulse (IDLE→CHECK→FIN).
- Miss: `sd_rd`/`sd_wr` asserts 2 cycles after the request pulse. `done` follows 2 cycles after `sd_ack` falls.
- `fdc_dout` and `sd_buff_din` have 1-cycle read latency from their address inputs.
- `sd_ack` is used directly; it is synchronous to `clk_sys` inside `mist_io`. Falling-edge detection uses a one-flop delay.
- Reset mid-transaction drops `sd_rd`/`sd_wr` immediately, and `valid` is cleared.

## Test plan
- Mount a 1 MiB image, `req_rd` LBA 5. Model returns bytes = addr[7:0]. Expect `sd_lba`=5, one `sd_rd[0]` handshake, `done`, `err`=0, and FDC readback RAM[0x1FF]=0xFF.
- Repeat `req_rd` LBA 5 → `done` 3 cycles later with no `sd_rd` assertion. Then issue `img_mounted[0]` and `req_rd` LBA 5 again → full SD read occurs.
- FDC writes 0xA5 to address 0x10, then `req_wr` LBA 7 → `sd_wr[0]` handshake, model captures 0xA5 at offset 0x10, `done`.
- `req_rd` LBA 2048 on a 1 MiB image, and any request with no image mounted → `done` + `err`=1, `sd_rd` never asserts.
- `req_rd` and `req_wr` pulsed together → write performed. A second `req_rd` while `busy` is ignored: exactly one `done`.
- Assert `reset` while `sd_rd[0]` is high → `sd_rd`=0 and `busy`=0 the same cycle. The next `req_rd` of the previous LBA misses.
